camera_pose_ctrl: RTL and testbench
===================================

// Module: camera_pose_ctrl
// PURPOSE
//  Upstream of the map renderer. Owns the player pose: ballx/bally in 8.8 fixed point and view angle in degrees 0..359.
//  Reads turn/move buttons. Updates the pose once per frame, at the first vblank pixel.
//  Publishes outputs only during vblank, so the renderer sees a constant pose for the whole active frame (no tearing).
// PARAMETERS
//  WIDTH       160  map width in pixels; x clamp bound
//  HEIGHT      90   map height in pixels; y clamp bound
//  H_ACTIVE    1280 active pixels per line (documentation/bench only)
//  V_ACTIVE    720  active lines; frame strobe at vcount_in==V_ACTIVE
//  ROT_STEP    2    degrees turned per frame while a turn button is held
//  SPEED       16   move step per frame, 1/256 px units (8.8 LSBs)
//  MAX_SPEED   64   ramp ceiling; used only with CAM_SPEED_RAMP_EN
//  START_X     80   reset x, integer pixels
//  START_Y     45   reset y, integer pixels
//  START_ANGLE 90   reset angle, degrees
// PORTS
//  pixel_clk_in    in  1   pixel clock; the only clock
//  rst_n_in        in  1   reset: one clock; asynchronous, active-low
//  hcount_in       in  11  raster column
//  vcount_in       in  10  raster line
//  btn_left_in     in  1   turn +ROT_STEP (counter-clockwise)
//  btn_right_in    in  1   turn -ROT_STEP
//  btn_fwd_in      in  1   move along the view direction
//  btn_back_in     in  1   move against the view direction
//  ballx_out       out 16  x position, 8.8 unsigned
//  bally_out       out 16  y position, 8.8 unsigned
//  angle_out       out 16  view angle, 0..359
//  pose_valid_out  out 1   one-cycle pulse when a new pose is committed
//  frame_count_out out 16  committed frames, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   ballx_out=START_X<<8, bally_out=START_Y<<8, angle_out=START_ANGLE.
//   pose_valid_out=0, frame_count_out=0, FSM=IDLE, speed=SPEED.
//  Buttons are sampled on the strobe cycle only; changes mid-frame have no effect until the next strobe.
//  FSM:
//   IDLE  : on strobe (vcount_in==V_ACTIVE && hcount_in==0), latch buttons and compute the new angle -> TURN.
//   TURN  : drive the new angle into cos_sin_lookup (1-cycle latency) -> WAIT.
//   WAIT  : LUT output valid -> MOVE.
//   MOVE  : compute and clamp the new position -> COMMIT.
//   COMMIT: register all outputs; pose_valid_out=1 for this cycle only; frame_count_out++ -> IDLE.
//  Latency: outputs update 4 cycles after the strobe cycle.
//  Angle:
//   left only: a+ROT_STEP; if the result is >=360, subtract 360.
//   right only: a-ROT_STEP; if a<ROT_STEP, the result is a+360-ROT_STEP.
//   Both or neither held: angle unchanged.
//  Move uses the NEW angle. cos/sin magnitude is 8 fractional bits (256 = 1.0).
//   d = (speed*mag)>>8.
//   fwd: x -= d*sgn(cos), y += d*sgn(sin). back: signs inverted. Both or neither held: no move.
//   Compute in signed 18-bit; clamp x to [0, (WIDTH-1)<<8] and y to [0, (HEIGHT-1)<<8]; no wrap.
//  A strobe arriving while not in IDLE is ignored; cannot occur at legal raster timing.
//  Reset mid-sequence aborts the update; outputs return to their reset values.
// CONFIGURATION
//  CAM_SPEED_RAMP_EN defined:
//   While fwd or back is held at a strobe, speed += 4 per frame, saturating at MAX_SPEED.
//   Speed returns to SPEED on the first strobe with neither button held.
//  Not defined: speed is constant SPEED; MAX_SPEED is unused.
// STRUCTURE
//  Package cam_pose_pkg:
//   state enum {IDLE, TURN, WAIT, MOVE, COMMIT}.
//   ANGLE_WRAP=360, FRAC_BITS=8, RAMP_STEP=4.
//  Sub-module: the existing cos_sin_lookup, one instance; no new sub-modules.
// TESTING
//  1 Reset, no buttons, 3 frames -> pose=(0x5000,0x2D00,90); pose_valid 3 pulses; frame_count=3.
//  2 angle=358, left held 1 frame -> angle=0. Then right held 1 frame -> angle=358.
//  3 angle=0, fwd held 1 frame -> ballx -=16, bally unchanged. Back held -> ballx returns to 0x5000.
//  4 ballx=0x0008, angle=0, fwd held -> ballx clamps to 0. bally at 0x5900, angle=270, back held -> bally stays at 0x5900.
//  5 left+right+fwd+back held together -> pose unchanged, pose_valid still pulses, frame_count increments.
//  6 Button toggled during active video only -> no change. Ramp (macro on), fwd held 20 frames -> speed caps at 64.
//    Reset asserted in MOVE -> outputs back to reset values.

Source files
------------

// File: rtl/cam_pose_pkg.sv
// Shared types and helpers for the camera pose controller: FSM states,
// the latched button bundle, angle stepping and position clamping.
package cam_pose_pkg;

    typedef enum logic [2:0] {IDLE, TURN, WAIT, MOVE, COMMIT} state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic fwd;
        logic back;
    } btn_t;

    localparam int ANGLE_WRAP = 360;
    localparam int FRAC_BITS  = 8;
    localparam int RAMP_STEP  = 4;

    // Opposing turn buttons cancel; the result always stays in 0..359.
    function automatic logic [8:0] turn_angle(input logic [8:0] a, input btn_t b, input int step);
        int s;
        s = int'(a);
        if (b.left && !b.right) begin
            s = s + step;
            if (s >= ANGLE_WRAP) s = s - ANGLE_WRAP;
        end else if (b.right && !b.left) begin
            s = (s < step) ? s + ANGLE_WRAP - step : s - step;
        end
        return 9'(s);
    endfunction

    function automatic logic [15:0] clamp_pos(input logic signed [17:0] v, input logic [15:0] hi);
        if (v < 0) return 16'd0;
        if (v > $signed({2'b00, hi})) return hi;
        return v[15:0];
    endfunction

endpackage

// File: rtl/cos_sin_lookup.sv
// Quarter-wave cos/sin table: magnitudes with 8 fractional bits (256 = 1.0)
// plus sign flags, one clock of latency. Input angle must be 0..359.
module cos_sin_lookup (
    input  logic       clk,
    input  logic [8:0] angle,
    output logic [8:0] cos_mag,
    output logic [8:0] sin_mag,
    output logic       cos_neg,
    output logic       sin_neg
);

    // round(256*sin(d)) for d = 0..90
    localparam logic [8:0] SIN_ROM [0:90] = '{
          0,   4,   9,  13,  18,  22,  27,  31,  36,  40,
         44,  49,  53,  58,  62,  66,  71,  75,  79,  83,
         88,  92,  96, 100, 104, 108, 112, 116, 120, 124,
        128, 132, 136, 139, 143, 147, 150, 154, 158, 161,
        165, 168, 171, 175, 178, 181, 184, 187, 190, 193,
        196, 199, 202, 204, 207, 210, 212, 215, 217, 219,
        222, 224, 226, 228, 230, 232, 234, 236, 237, 239,
        241, 242, 243, 245, 246, 247, 248, 249, 250, 251,
        252, 253, 254, 254, 255, 255, 255, 256, 256, 256,
        256
    };

    logic [8:0] fold_full;
    logic [6:0] sin_idx;
    logic [6:0] cos_idx;

    // Fold into the first quadrant; |cos(a)| is sin of the complementary angle.
    always_comb begin
        if (angle <= 9'd90)       fold_full = angle;
        else if (angle <= 9'd180) fold_full = 9'd180 - angle;
        else if (angle <= 9'd270) fold_full = angle - 9'd180;
        else                      fold_full = 9'd360 - angle;
        sin_idx = fold_full[6:0];
        cos_idx = 7'd90 - sin_idx;
    end

    always_ff @(posedge clk) begin
        sin_mag <= SIN_ROM[sin_idx];
        cos_mag <= SIN_ROM[cos_idx];
        sin_neg <= (angle > 9'd180);
        cos_neg <= (angle > 9'd90) && (angle < 9'd270);
    end

endmodule

// File: rtl/camera_pose_ctrl.sv
// Player pose owner: updates x/y/angle once per frame at the first vblank pixel
// and publishes only then. Optional speed ramp: define CAM_SPEED_RAMP_EN.
module camera_pose_ctrl
    import cam_pose_pkg::*;
#(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 90,
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int ROT_STEP    = 2,
    parameter int SPEED       = 16,
    parameter int MAX_SPEED   = 64,
    parameter int START_X     = 80,
    parameter int START_Y     = 45,
    parameter int START_ANGLE = 90
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        btn_fwd_in,
    input  logic        btn_back_in,
    output logic [15:0] ballx_out,
    output logic [15:0] bally_out,
    output logic [15:0] angle_out,
    output logic        pose_valid_out,
    output logic [15:0] frame_count_out
);

    localparam logic [15:0] X_START = 16'(START_X << FRAC_BITS);
    localparam logic [15:0] Y_START = 16'(START_Y << FRAC_BITS);
    localparam logic [15:0] X_MAX   = 16'((WIDTH - 1) << FRAC_BITS);
    localparam logic [15:0] Y_MAX   = 16'((HEIGHT - 1) << FRAC_BITS);

    state_t      state_reg, state_next;
    btn_t        btn_sample, btn_reg;
    logic [8:0]  angle_reg, angle_new_reg;
    logic [15:0] ballx_reg, bally_reg, frame_count_reg;
    logic [7:0]  move_speed;
    logic        strobe;
    logic [8:0]  cos_mag, sin_mag;
    logic        cos_neg, sin_neg;
    logic [16:0] prod_x, prod_y;
    logic signed [17:0] dx_s, dy_s, delta_x, delta_y, x_sum, y_sum;
    logic [31:0] unused_params;

    assign unused_params = 32'(H_ACTIVE) ^ 32'(MAX_SPEED);
    assign strobe     = (vcount_in == 10'(V_ACTIVE)) && (hcount_in == 11'd0);
    assign btn_sample = '{left: btn_left_in, right: btn_right_in, fwd: btn_fwd_in, back: btn_back_in};

    cos_sin_lookup u_lut (
        .clk     (pixel_clk_in),
        .angle   (angle_new_reg),
        .cos_mag (cos_mag),
        .sin_mag (sin_mag),
        .cos_neg (cos_neg),
        .sin_neg (sin_neg)
    );

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_reg <= IDLE;
        else           state_reg <= state_next;
    end

    // Strobes outside IDLE are dropped; legal raster timing never produces one.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (strobe) state_next = TURN;
            TURN:    state_next = WAIT;
            WAIT:    state_next = MOVE;
            MOVE:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pose_valid_out = (state_reg == COMMIT);
    end

`ifdef CAM_SPEED_RAMP_EN
    logic [7:0] speed_reg, move_speed_reg;

    // The frame's move uses the speed held before this strobe's ramp step.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            speed_reg      <= 8'(SPEED);
            move_speed_reg <= 8'(SPEED);
        end else if (state_reg == IDLE && strobe) begin
            move_speed_reg <= speed_reg;
            if (btn_sample.fwd || btn_sample.back)
                speed_reg <= (int'(speed_reg) + RAMP_STEP >= MAX_SPEED) ? 8'(MAX_SPEED)
                                                                        : speed_reg + 8'(RAMP_STEP);
            else
                speed_reg <= 8'(SPEED);
        end
    end

    assign move_speed = move_speed_reg;
`else
    assign move_speed = 8'(SPEED);
`endif

    always_comb begin
        prod_x  = 17'(move_speed) * 17'(cos_mag);
        prod_y  = 17'(move_speed) * 17'(sin_mag);
        dx_s    = $signed(18'(prod_x[16:8]));
        dy_s    = $signed(18'(prod_y[16:8]));
        delta_x = 18'sd0;
        delta_y = 18'sd0;
        if (btn_reg.fwd && !btn_reg.back) begin
            delta_x = cos_neg ? dx_s : -dx_s;
            delta_y = sin_neg ? -dy_s : dy_s;
        end else if (btn_reg.back && !btn_reg.fwd) begin
            delta_x = cos_neg ? -dx_s : dx_s;
            delta_y = sin_neg ? dy_s : -dy_s;
        end
        x_sum = $signed({2'b00, ballx_reg}) + delta_x;
        y_sum = $signed({2'b00, bally_reg}) + delta_y;
    end

    // Published registers load on the MOVE->COMMIT edge so the new pose and
    // the valid pulse appear together in the COMMIT cycle.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            btn_reg         <= '0;
            angle_new_reg   <= 9'(START_ANGLE);
            angle_reg       <= 9'(START_ANGLE);
            ballx_reg       <= X_START;
            bally_reg       <= Y_START;
            frame_count_reg <= 16'd0;
        end else begin
            if (state_reg == IDLE && strobe) begin
                btn_reg       <= btn_sample;
                angle_new_reg <= turn_angle(angle_reg, btn_sample, ROT_STEP);
            end
            if (state_reg == MOVE) begin
                ballx_reg       <= clamp_pos(x_sum, X_MAX);
                bally_reg       <= clamp_pos(y_sum, Y_MAX);
                angle_reg       <= angle_new_reg;
                frame_count_reg <= frame_count_reg + 16'd1;
            end
        end
    end

    assign ballx_out       = ballx_reg;
    assign bally_out       = bally_reg;
    assign angle_out       = {7'd0, angle_reg};
    assign frame_count_out = frame_count_reg;

endmodule

// File: tb/tb_camera_pose_ctrl.sv
// Scoreboard bench for camera_pose_ctrl: a trigonometric reference model
// predicts each committed pose; a monitor checks every pose_valid pulse.
module tb_camera_pose_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_fwd = 1'b0, btn_back = 1'b0;
    logic [15:0] ballx, bally, angle, frame_count;
    logic        pose_valid;

    always #5 clk = ~clk;

    camera_pose_ctrl dut (
        .pixel_clk_in    (clk),
        .rst_n_in        (rst_n),
        .hcount_in       (hcount),
        .vcount_in       (vcount),
        .btn_left_in     (btn_left),
        .btn_right_in    (btn_right),
        .btn_fwd_in      (btn_fwd),
        .btn_back_in     (btn_back),
        .ballx_out       (ballx),
        .bally_out       (bally),
        .angle_out       (angle),
        .pose_valid_out  (pose_valid),
        .frame_count_out (frame_count)
    );

    typedef struct {
        int x;
        int y;
        int a;
        int fc;
    } pose_t;

    pose_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int mx, my, ma, mspeed, mfc;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && pose_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_pose_valid actual=1 required=0");
            end else begin
                pose_t e;
                e = exp_q.pop_front();
                $display("[TB] pose fc=%0d x=%h y=%h angle=%0d", frame_count, ballx, bally, angle);
                check("ballx", int'(ballx), e.x);
                check("bally", int'(bally), e.y);
                check("angle", int'(angle), e.a);
                check("frame_count", int'(frame_count), e.fc);
            end
        end
    end

    function automatic void model_reset();
        mx = 80 * 256;
        my = 45 * 256;
        ma = 90;
        mspeed = 16;
        mfc = 0;
    endfunction

    // Rounded 256*cos/sin magnitude and sign for an integer angle in degrees.
    function automatic void trig(input int deg, output int cmag, output int csgn,
                                 output int smag, output int ssgn);
        real rad, c, s;
        rad  = real'(deg) * 3.14159265358979 / 180.0;
        c    = $cos(rad);
        s    = $sin(rad);
        cmag = int'($floor(256.0 * ((c < 0.0) ? -c : c) + 0.5));
        smag = int'($floor(256.0 * ((s < 0.0) ? -s : s) + 0.5));
        csgn = (cmag == 0) ? 0 : ((c < 0.0) ? -1 : 1);
        ssgn = (smag == 0) ? 0 : ((s < 0.0) ? -1 : 1);
    endfunction

    function automatic void model_frame(input bit l, input bit r, input bit f, input bit b);
        int cmag, csgn, smag, ssgn, use_speed, dirv, dx, dy;
        pose_t e;
        if (l && !r)      ma = (ma + 2) % 360;
        else if (r && !l) ma = (ma + 358) % 360;
        use_speed = mspeed;
`ifdef CAM_SPEED_RAMP_EN
        if (f || b) mspeed = (mspeed + 4 > 64) ? 64 : mspeed + 4;
        else        mspeed = 16;
`endif
        dirv = (f && !b) ? 1 : ((b && !f) ? -1 : 0);
        trig(ma, cmag, csgn, smag, ssgn);
        dx = (use_speed * cmag) / 256;
        dy = (use_speed * smag) / 256;
        mx = mx - dirv * csgn * dx;
        my = my + dirv * ssgn * dy;
        if (mx < 0) mx = 0;
        if (mx > 159 * 256) mx = 159 * 256;
        if (my < 0) my = 0;
        if (my > 89 * 256) my = 89 * 256;
        mfc = (mfc + 1) % 65536;
        e.x = mx; e.y = my; e.a = ma; e.fc = mfc;
        exp_q.push_back(e);
    endfunction

    task automatic drive_random_buttons();
        {btn_left, btn_right, btn_fwd, btn_back} = 4'($urandom);
    endtask

    task automatic do_frame(input bit l, input bit r, input bit f, input bit b);
        @(posedge clk); #1;
        {btn_left, btn_right, btn_fwd, btn_back} = {l, r, f, b};
        vcount = 10'd720;
        hcount = 11'd0;
        model_frame(l, r, f, b);
        @(posedge clk); #1;
        hcount = 11'd1;
        drive_random_buttons();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            check("commit_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        // Active video with button noise must leave the published pose alone.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vcount = 10'($urandom_range(0, 719));
            hcount = 11'($urandom_range(0, 1279));
            drive_random_buttons();
        end
        @(negedge clk);
        check("hold_ballx", int'(ballx), mx);
        check("hold_angle", int'(angle), ma);
    endtask

    task automatic check_reset_outputs();
        check("rst_ballx", int'(ballx), 16'h5000);
        check("rst_bally", int'(bally), 16'h2D00);
        check("rst_angle", int'(angle), 90);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_pose_valid", int'(pose_valid), 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // No buttons for three frames.
        repeat (3) do_frame(0, 0, 0, 0);
        check("t1_frame_count", int'(frame_count), 3);
        check("t1_ballx", int'(ballx), 16'h5000);

        // Angle wrap both ways through 0.
        repeat (46) do_frame(0, 1, 0, 0);
        check("t2_angle_358", int'(angle), 358);
        do_frame(1, 0, 0, 0);
        check("t2_wrap_up", int'(angle), 0);
        do_frame(0, 1, 0, 0);
        check("t2_wrap_down", int'(angle), 358);
        do_frame(1, 0, 0, 0);

        // Forward then back along angle 0.
        do_frame(0, 0, 1, 0);
        check("t3_fwd_x", int'(ballx), 16'h5000 - 16);
        check("t3_fwd_y", int'(bally), 16'h2D00);
        do_frame(0, 0, 0, 1);
        check("t3_back_x", int'(ballx), 16'h5000);

        // Drive into the x=0 wall, then into the y max wall at 270 degrees.
        repeat (1285) do_frame(0, 0, 1, 0);
        check("t4_x_clamp", int'(ballx), 0);
        repeat (45) do_frame(0, 1, 0, 0);
        check("t4_angle_270", int'(angle), 270);
        repeat (710) do_frame(0, 0, 0, 1);
        check("t4_y_clamp", int'(bally), 16'h5900);

        // All buttons cancel.
        do_frame(1, 1, 1, 1);
        check("t5_angle", int'(angle), 270);

        // Random button patterns.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] bt;
            bt = 4'($urandom);
            do_frame(bt[3], bt[2], bt[1], bt[0]);
        end
`ifdef CAM_SPEED_RAMP_EN
        repeat (20) do_frame(0, 0, 1, 0);
`endif

        // Reset during MOVE aborts the update.
        @(posedge clk); #1;
        {btn_left, btn_right, btn_fwd, btn_back} = 4'b1010;
        vcount = 10'd720;
        hcount = 11'd0;
        @(posedge clk); #1;
        hcount = 11'd1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #2;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_frame(0, 0, 1, 0);
        check("post_rst_frame_count", int'(frame_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
